// File: rtl/urp_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// urp_pcie_tx_arbiter
//
// Purpose:
//   Arbitrates three PCIe transmit request classes (posted, non-posted,
//   completion) onto a single registered TLP header/payload port toward the
//   transaction layer. Each class holds a header-credit counter; a class is
//   eligible only while it is requesting and has credit. Arbitration happens
//   in IDLE only; the winning TLP is latched and presented in SEND until the
//   transaction layer accepts it, giving at most one TLP every two cycles.
//
// Optional feature (compile-time macro):
//   URP_TX_ARB_CPL_PRIORITY_EN - when defined, an eligible completion
//   (class 2) always wins; classes 0 and 1 round-robin between themselves.
//   When undefined, plain 3-way round-robin is used.
//
// Handshake semantics:
//   Request side: req_ready_o[k] is a single-cycle accept pulse, asserted
//   combinationally in IDLE for the winning class only. The request is
//   consumed on the rising edge where req_valid_i[k] and req_ready_o[k] are
//   both high; a request withdrawn before that edge leaves no trace.
//   TLP side: tlp_valid_o is high for the whole SEND state. Fields hold
//   stable until the rising edge where tlp_valid_o and tlp_ready_i are both
//   high, which completes the transfer.
//
// Ports:
//   clk                 in   1    clock, all state on rising edge
//   rst                 in   1    asynchronous reset, active-high
//   req_valid_i         in   3    per-class request (0 P, 1 NP, 2 CPL)
//   req_ready_o         out  3    one-cycle accept pulse to the winner
//   req_hdr_i           in   255  class k header at [85k+84:85k]
//   req_payload_i       in   384  class k payload at [128k+127:128k]
//   payload_o           out  128  latched payload
//   addr_o .. header_completID_o  latched header fields
//   tlp_valid_o         out  1    output fields valid (state SEND)
//   tlp_ready_i         in   1    transaction layer accepts the fields
//   credit_return_i     in   3    per-class header credit return pulse
//   grant_o             out  3    one-hot owner of the TLP in flight
//   state_o             out  1    debug view of the FSM: 0 IDLE, 1 SEND
// ---------------------------------------------------------------------------
module urp_pcie_tx_arbiter #(
    parameter int CREDIT_INIT = 8,
    parameter int CREDIT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   req_valid_i,
    output logic [2:0]   req_ready_o,
    input  logic [254:0] req_hdr_i,
    input  logic [383:0] req_payload_i,
    output logic [127:0] payload_o,
    output logic [31:0]  addr_o,
    output logic [2:0]   header_fmt_o,
    output logic [4:0]   header_type_o,
    output logic [2:0]   header_tc_o,
    output logic [9:0]   header_length_o,
    output logic [15:0]  header_requestID_o,
    output logic [15:0]  header_completID_o,
    output logic         tlp_valid_o,
    input  logic         tlp_ready_i,
    input  logic [2:0]   credit_return_i,
    output logic [2:0]   grant_o,
    output logic         state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDIT_INIT);

    state_t              state;
    state_t              state_next;
    logic [CREDIT_W-1:0] credit [3];
    logic [1:0]          last_grant;
    logic [2:0]          eligible;
    logic                win_valid;
    logic [1:0]          win_idx;
    logic                accept;
    logic [84:0]         sel_hdr;
    logic [127:0]        sel_pay;
    logic [84:0]         hdr_q;
    logic [127:0]        pay_q;

`ifdef URP_TX_ARB_CPL_PRIORITY_EN
    // Last winner among the two low classes; 1 after reset so class 0
    // is preferred first.
    logic                last_lo;
`endif

    // -----------------------------------------------------------------------
    // Eligibility
    // -----------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            eligible[k] = req_valid_i[k] && (credit[k] != '0);
        end
    end

    // -----------------------------------------------------------------------
    // Winner selection. Only the winner moves the pointer, so classes that
    // are skipped for lack of credit never disturb the rotation.
    // -----------------------------------------------------------------------
    always_comb begin
        win_valid = |eligible;
        win_idx   = 2'd0;
`ifdef URP_TX_ARB_CPL_PRIORITY_EN
        if (eligible[2]) begin
            win_idx = 2'd2;
        end else if (last_lo) begin
            if (eligible[0])      win_idx = 2'd0;
            else if (eligible[1]) win_idx = 2'd1;
        end else begin
            if (eligible[1])      win_idx = 2'd1;
            else if (eligible[0]) win_idx = 2'd0;
        end
`else
        case (last_grant)
            2'd0: begin
                if (eligible[1])      win_idx = 2'd1;
                else if (eligible[2]) win_idx = 2'd2;
                else if (eligible[0]) win_idx = 2'd0;
            end
            2'd1: begin
                if (eligible[2])      win_idx = 2'd2;
                else if (eligible[0]) win_idx = 2'd0;
                else if (eligible[1]) win_idx = 2'd1;
            end
            default: begin
                if (eligible[0])      win_idx = 2'd0;
                else if (eligible[1]) win_idx = 2'd1;
                else if (eligible[2]) win_idx = 2'd2;
            end
        endcase
`endif
    end

    // Header/payload of the current winner.
    always_comb begin
        case (win_idx)
            2'd0: begin
                sel_hdr = req_hdr_i[84:0];
                sel_pay = req_payload_i[127:0];
            end
            2'd1: begin
                sel_hdr = req_hdr_i[169:85];
                sel_pay = req_payload_i[255:128];
            end
            default: begin
                sel_hdr = req_hdr_i[254:170];
                sel_pay = req_payload_i[383:256];
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: next state and accept pulse. The accept pulse is gated with rst
    // so that no request is acknowledged while reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        req_ready_o = 3'b000;
        case (state)
            IDLE: begin
                if (win_valid && !rst) begin
                    accept      = 1'b1;
                    req_ready_o = 3'b001 << win_idx;
                    state_next  = SEND;
                end
            end
            SEND: begin
                if (tlp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers, grant and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q      <= '0;
            pay_q      <= '0;
            grant_o    <= 3'b000;
            last_grant <= 2'd2;
        end else begin
            if (accept) begin
                hdr_q      <= sel_hdr;
                pay_q      <= sel_pay;
                grant_o    <= req_ready_o;
                last_grant <= win_idx;
            end else if (state == SEND && tlp_ready_i) begin
                grant_o    <= 3'b000;
            end
        end
    end

`ifdef URP_TX_ARB_CPL_PRIORITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lo <= 1'b1;
        end else if (accept && win_idx != 2'd2) begin
            last_lo <= win_idx[0];
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Credit counters. A grant and a return in the same cycle cancel out;
    // returns saturate at the initial credit value.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                credit[k] <= CREDIT_MAX;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (req_ready_o[k] && !credit_return_i[k]) begin
                    credit[k] <= credit[k] - 1'b1;
                end else if (!req_ready_o[k] && credit_return_i[k] &&
                             credit[k] < CREDIT_MAX) begin
                    credit[k] <= credit[k] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping: {addr32, fmt3, type5, tc3, length10, reqID16, cplID16}
    // -----------------------------------------------------------------------
    assign addr_o             = hdr_q[84:53];
    assign header_fmt_o       = hdr_q[52:50];
    assign header_type_o      = hdr_q[49:45];
    assign header_tc_o        = hdr_q[44:42];
    assign header_length_o    = hdr_q[41:32];
    assign header_requestID_o = hdr_q[31:16];
    assign header_completID_o = hdr_q[15:0];
    assign payload_o          = pay_q;
    assign tlp_valid_o        = (state == SEND);
    assign state_o            = state;

endmodule

// File: tb/tb_urp_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_urp_pcie_tx_arbiter
//
// Bench for urp_pcie_tx_arbiter. Inputs change 1 ns after a rising edge;
// outputs are sampled on the falling edge. A reference model (credit
// counts, last winner, in-flight TLP) predicts every output each cycle, and
// an expected queue holds the TLPs that must be delivered, in order.
// Directed sections pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_urp_pcie_tx_arbiter;

    localparam int CREDIT_INIT = 8;
    localparam int CREDIT_W    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [254:0] req_hdr;
    logic [383:0] req_payload;
    logic [127:0] payload;
    logic [31:0]  addr;
    logic [2:0]   header_fmt;
    logic [4:0]   header_type;
    logic [2:0]   header_tc;
    logic [9:0]   header_length;
    logic [15:0]  header_requestID;
    logic [15:0]  header_completID;
    logic         tlp_valid;
    logic         tlp_ready;
    logic [2:0]   credit_return;
    logic [2:0]   grant;
    logic         state_dbg;
    logic [84:0]  dut_hdr;

    assign dut_hdr = {addr, header_fmt, header_type, header_tc, header_length,
                      header_requestID, header_completID};

    urp_pcie_tx_arbiter #(
        .CREDIT_INIT (CREDIT_INIT),
        .CREDIT_W    (CREDIT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_hdr_i          (req_hdr),
        .req_payload_i      (req_payload),
        .payload_o          (payload),
        .addr_o             (addr),
        .header_fmt_o       (header_fmt),
        .header_type_o      (header_type),
        .header_tc_o        (header_tc),
        .header_length_o    (header_length),
        .header_requestID_o (header_requestID),
        .header_completID_o (header_completID),
        .tlp_valid_o        (tlp_valid),
        .tlp_ready_i        (tlp_ready),
        .credit_return_i    (credit_return),
        .grant_o            (grant),
        .state_o            (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [212:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_busy;
    int           m_own;
    int           m_credit[3];
    int           m_last;
    int           m_last_lo;
    logic [84:0]  m_hdr;
    logic [127:0] m_pay;

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_own     = 0;
        m_last    = 2;
        m_last_lo = 1;
        m_hdr     = '0;
        m_pay     = '0;
        for (int k = 0; k < 3; k++) m_credit[k] = CREDIT_INIT;
    endfunction

    // Which class the rules say must win, or -1 if none is eligible.
    function automatic int model_pick(input logic [2:0] v);
        bit e[3];
        for (int k = 0; k < 3; k++) e[k] = v[k] && (m_credit[k] > 0);
`ifdef URP_TX_ARB_CPL_PRIORITY_EN
        if (e[2]) return 2;
        for (int i = 1; i <= 2; i++) begin
            int c = (m_last_lo + i) % 2;
            if (e[c]) return c;
        end
        return -1;
`else
        for (int i = 1; i <= 3; i++) begin
            int c = (m_last + i) % 3;
            if (e[c]) return c;
        end
        return -1;
`endif
    endfunction

    // One compare process: check every output, then advance the model with
    // the inputs that the next rising edge will see.
    always @(negedge clk) begin
        int w;
        logic [2:0]   exp_ready;
        logic [2:0]   exp_grant;
        logic [212:0] tlp;
        if (rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_tlp_valid", tlp_valid, 0);
            check("rst_grant", grant, 0);
            check("rst_hdr", dut_hdr, 0);
            check("rst_payload", payload, 0);
            model_reset();
            exp_q.delete();
        end else begin
            w = m_busy ? -1 : model_pick(req_valid);
            exp_ready = (w >= 0) ? (3'b001 << w) : 3'b000;
            exp_grant = m_busy ? (3'b001 << m_own) : 3'b000;
            check("req_ready", req_ready, exp_ready);
            check("tlp_valid", tlp_valid, m_busy);
            check("grant", grant, exp_grant);
            if (m_busy) begin
                check("hdr", dut_hdr, m_hdr);
                check("payload", payload, m_pay);
            end
            if (m_busy && tlp_ready) begin
                if (exp_q.size() == 0) begin
                    check("tlp_delivered_unexpected", 1, 0);
                end else begin
                    tlp = exp_q.pop_front();
                    check("tlp_delivered", {dut_hdr, payload}, tlp);
                end
                m_busy = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (w == k && !credit_return[k]) m_credit[k]--;
                else if (w != k && credit_return[k] && m_credit[k] < CREDIT_INIT)
                    m_credit[k]++;
            end
            if (w >= 0) begin
                m_busy = 1'b1;
                m_own  = w;
                m_hdr  = req_hdr[85*w +: 85];
                m_pay  = req_payload[128*w +: 128];
                m_last = w;
                if (w != 2) m_last_lo = w;
                exp_q.push_back({m_hdr, m_pay});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        logic [255:0] h;
        logic [383:0] p;
        for (int i = 0; i < 8; i++)  h[32*i +: 32] = $urandom;
        for (int i = 0; i < 12; i++) p[32*i +: 32] = $urandom;
        req_hdr     = h[254:0];
        req_payload = p;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = 3'b000;
        tlp_ready     = 1'b0;
        credit_return = 3'b000;
        rand_data();
        repeat (3) step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [2:0]   exp_seq[8];
    logic [212:0] snap;
    int           cnt;
    int           cls_cnt[3];

    initial begin
        model_reset();
        req_valid     = 3'b000;
        tlp_ready     = 1'b0;
        credit_return = 3'b000;
        req_hdr       = '0;
        req_payload   = '0;

        // Arbitration order after reset, all classes requesting.
`ifdef URP_TX_ARB_CPL_PRIORITY_EN
        exp_seq = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000};
`else
        exp_seq = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
`endif
        do_reset();
        req_valid = 3'b111;
        tlp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_order_%0d", i), req_ready, exp_seq[i]);
        end
        step();

        // Credit exhaustion on class 0, then a single return.
        do_reset();
        req_valid = 3'b001;
        tlp_ready = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
        end
        check("credit_exhaust_accepts", cnt, 8);
        step();
        credit_return = 3'b001;
        step();
        credit_return = 3'b000;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
        end
        check("one_return_one_accept", cnt, 1);
        step();

        // Saturation at full credit, then grant+return in the same cycle.
        do_reset();
        credit_return = 3'b111;
        repeat (9) step();
        credit_return = 3'b000;
        req_valid     = 3'b010;
        tlp_ready     = 1'b1;
        credit_return = 3'b010;
        cnt = 0;
        @(negedge clk);
        check("grant_with_return", req_ready, 3'b010);
        if (req_ready[1]) cnt++;
        step();
        credit_return = 3'b000;
        repeat (40) begin
            @(negedge clk);
            if (req_ready[1]) cnt++;
        end
        check("cancel_and_saturate_accepts", cnt, 9);
        step();

        // Back-pressure: fields stay frozen while inputs churn.
        do_reset();
        req_valid = 3'b001;
        tlp_ready = 1'b0;
        step();
        @(negedge clk);
        snap = {dut_hdr, payload};
        step();
        for (int i = 0; i < 10; i++) begin
            req_valid = 3'b111;
            rand_data();
            @(negedge clk);
            check("stall_fields", {dut_hdr, payload}, snap);
            check("stall_valid_grant", {tlp_valid, grant, req_ready}, {1'b1, 3'b001, 3'b000});
            step();
        end
        tlp_ready = 1'b1;
        req_valid = 3'b000;
        step();
        step();

        // Reset in the middle of SEND.
        do_reset();
        req_valid = 3'b100;
        tlp_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rst_abort", {tlp_valid, grant}, 4'b0000);
        repeat (2) step();
        rst = 1'b0;
        req_valid = 3'b111;
        tlp_ready = 1'b1;
        @(negedge clk);
`ifdef URP_TX_ARB_CPL_PRIORITY_EN
        check("first_after_rst", req_ready, 3'b100);
`else
        check("first_after_rst", req_ready, 3'b001);
`endif
        for (int k = 0; k < 3; k++) cls_cnt[k] = (req_ready[k]) ? 1 : 0;
        repeat (70) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (req_ready[k]) cls_cnt[k]++;
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("credits_restored_%0d", k), cls_cnt[k], 8);
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid     = 3'($urandom_range(0, 7));
            tlp_ready     = ($urandom_range(0, 9) < 7);
            credit_return = 3'b000;
            for (int k = 0; k < 3; k++)
                credit_return[k] = ($urandom_range(0, 5) == 0);
            rand_data();
            step();
        end
        req_valid     = 3'b000;
        credit_return = 3'b000;
        tlp_ready     = 1'b1;
        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/urp_pcie_tx_arbiter.md
URP_PCIE_TX_ARBITER -- requirements
Module: URP_PCIE_TX_ARBITER

Interface
REQ-001 SHALL have parameter CREDIT_INIT, default 8: header credits per class at reset, and the saturation ceiling.
REQ-002 SHALL have parameter CREDIT_W, default 8: credit counter width; CREDIT_INIT SHALL be less than 2**CREDIT_W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port req_valid_i, input, 3 bits: per-class request; bit0 posted, bit1 non-posted, bit2 completion.
REQ-006 SHALL have port req_ready_o, output, 3 bits: one-cycle accept pulse to the granted requester.
REQ-007 SHALL have port req_hdr_i, input, 3x85 bits: per class {addr32, fmt3, type5, tc3, length10, requestID16, completID16}; class k occupies [85k+84:85k].
REQ-008 SHALL have port req_payload_i, input, 3x128 bits: per-class payload; class k occupies [128k+127:128k].
REQ-009 SHALL have ports payload_o 128, addr_o 32, header_fmt_o 3, header_type_o 5, header_tc_o 3, header_length_o 10, header_requestID_o 16 and header_completID_o 16, all outputs: registered fields toward the transaction layer.
REQ-010 SHALL have port tlp_valid_o, output, 1 bit: the output fields are valid.
REQ-011 SHALL have port tlp_ready_i, input, 1 bit: the transaction layer accepts the fields.
REQ-012 SHALL have port credit_return_i, input, 3 bits: per-class pulse returning one header credit.
REQ-013 SHALL have port grant_o, output, 3 bits: one-hot owner of the TLP in flight; zero when idle.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SEND.
REQ-015 A class SHALL be eligible when req_valid_i[k]=1 and credit[k]>0.
REQ-016 In IDLE with at least one eligible class, SHALL pick the winner round-robin, starting at class (last_grant+1) mod 3.
REQ-017 In the same IDLE cycle, SHALL pulse req_ready_o[winner], latch the winner's header and payload into the output registers, set grant_o, decrement credit[winner], update last_grant, and go to SEND.
REQ-018 tlp_valid_o SHALL be high exactly while in SEND, starting the cycle after the accept; latency from accept to valid is 1 cycle.
REQ-019 In SEND, outputs SHALL hold stable until tlp_valid_o and tlp_ready_i are both high; then SHALL clear tlp_valid_o and grant_o and return to IDLE.
REQ-020 Peak throughput SHALL be 1 TLP per 2 cycles; no arbitration occurs in SEND.
REQ-021 A credit_return_i[k] pulse SHALL increment credit[k], saturating at CREDIT_INIT.
REQ-022 A grant decrement and a return on the same class in the same cycle SHALL leave credit[k] unchanged.
REQ-023 A class with credit 0 SHALL be skipped without moving the round-robin pointer.
REQ-024 req_ready_o SHALL never have more than one bit set and SHALL be 0 in SEND.
REQ-025 Requests deasserted before acceptance SHALL be dropped without side effects.

Reset
REQ-026 While rst=1, SHALL force: state IDLE; tlp_valid_o, req_ready_o and grant_o 0; all data outputs 0; credit[0..2] = CREDIT_INIT; last_grant = 2, so class 0 wins first.
REQ-027 Reset asserted in SEND SHALL abort the TLP in flight immediately; the consumed credit SHALL be restored by the reset value.

Configuration
REQ-028 Macro URP_TX_ARB_CPL_PRIORITY_EN, when defined, SHALL give an eligible completion (class 2) strict priority over classes 0 and 1; classes 0 and 1 SHALL stay round-robin between themselves.
REQ-029 Without URP_TX_ARB_CPL_PRIORITY_EN, SHALL use plain 3-way round-robin as in REQ-016.

Verification
REQ-030 After reset, req_valid_i=3'b111 and tlp_ready_i=1 -> grants in order 0,1,2,0 on accept cycles 1,3,5,7 (with the macro: 2,2,2,...).
REQ-031 req_valid_i=3'b001 with no credit returns -> exactly 8 accepts, then req_ready_o stays 0; one credit_return_i[0] pulse -> exactly one further accept.
REQ-032 tlp_ready_i held 0 for 10 cycles in SEND -> tlp_valid_o, grant_o and all fields stable; req_ready_o=0 throughout.
REQ-033 Grant of class 1 and credit_return_i[1] in the same cycle -> credit[1] unchanged; 9 returns at full credit -> credit stays 8.
REQ-034 rst pulsed during SEND -> the same cycle shows tlp_valid_o=0 and grant_o=0; after release all credits are 8 and class 0 wins first.
